vga_pixel_out: RTL and testbench

- Downstream stage of the 640x480 VGA timing generator. Consumes its H_SYNC/V_SYNC/PIXEL/P_COUNT outputs.
- Fetches pixels from a synchronous-read frame buffer, or generates a test pattern.
- Delay-matches the sync signals to the data path and drives the registered RGB444 + sync pins.
- Also provides a frame-start pulse and a frame counter for display/debug logic.

---
 rtl/vga_pixel_out_pkg.sv | 52 +++++
 rtl/vga_pixel_out_if.sv | 17 +
 rtl/vga_pixel_out_delay.sv | 33 +++
 rtl/vga_pixel_out.sv | 171 +++++++++++++++++
 tb/tb_vga_pixel_out.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pixel_out_pkg.sv
// Shared definitions for the VGA pixel output stage.
//   - mode_e     : source select encodings (frame buffer / bars / checker / solid)
//   - COL_*      : the eight colour-bar colours, RGB444 {R,G,B}
//   - ctl_t      : sync/pixel control bundle carried through the delay line
//   - bar_colour : bar index -> colour lookup
package vga_pixel_out_pkg;

  typedef enum logic [1:0] {
    MODE_FB    = 2'b00,
    MODE_BARS  = 2'b01,
    MODE_CHECK = 2'b10,
    MODE_SOLID = 2'b11
  } mode_e;

  localparam int BAR_WIDTH    = 80;
  localparam int H_ACTIVE_PIX = 640;
  localparam int V_ACTIVE_PIX = 480;

  localparam logic [11:0] COL_WHITE   = 12'hFFF;
  localparam logic [11:0] COL_YELLOW  = 12'hFF0;
  localparam logic [11:0] COL_CYAN    = 12'h0FF;
  localparam logic [11:0] COL_GREEN   = 12'h0F0;
  localparam logic [11:0] COL_MAGENTA = 12'hF0F;
  localparam logic [11:0] COL_RED     = 12'hF00;
  localparam logic [11:0] COL_BLUE    = 12'h00F;
  localparam logic [11:0] COL_BLACK   = 12'h000;

  // Everything that must arrive at the output register in step with the pixel data.
  typedef struct packed {
    logic  hs;    // active-low hsync
    logic  vs;    // active-low vsync
    logic  pix;   // active video
    logic  fs;    // first pixel of frame
    mode_e mode;  // source selected for this pixel
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, pix: 1'b0, fs: 1'b0, mode: MODE_FB};

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pixel_out_if.sv
// Frame-buffer read port.
//   rd_en   : read strobe              (master -> slave)
//   rd_addr : linear pixel address     (master -> slave)
//   rd_data : RGB444 pixel, valid RAM_LAT cycles after rd_en (slave -> master)
interface vga_pixel_out_if
  import vga_pixel_out_pkg::*;
#(
  parameter int ADDR_W = $clog2(H_ACTIVE_PIX * V_ACTIVE_PIX),
  parameter int DATA_W = 12
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input  rd_data);
  modport slave  (input  rd_en, input  rd_addr, output rd_data);
endinterface

// File: rtl/vga_pixel_out_delay.sv
// vga_delay_line: fixed-depth shift register with asynchronous reset to RST_VAL.
//   clk, rst : clock, async active-high reset
//   i_d      : WIDTH-bit input, sampled every cycle
//   o_q      : i_d delayed by DEPTH cycles (DEPTH >= 1)
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // NOTE: sequential state uses <= so every stage samples the pre-edge value of its
  // neighbour; blocking assignments here would collapse the chain into one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this array is a small flop chain, not a RAM, so clearing every entry on
      // reset is cheap and is what makes mid-frame reset blank the pipeline.
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_out.sv
// vga_pixel_out: final VGA stage behind the 640x480 timing generator.
// Fetches pixels from a synchronous frame buffer or generates a test pattern,
// delay-matches syncs to the data and drives registered RGB444 + sync pins.
// Every output lags its input cycle by RAM_LAT+1 cycles in all modes.
//   clk, rst          : pixel clock, async active-high reset
//   i_h_sync/i_v_sync : active-low syncs from timing generator
//   i_pixel           : active-video flag
//   i_p_count         : linear active-pixel index
//   i_mode            : requested source, latched at the start of vsync
//   i_solid_rgb       : colour for solid mode
//   fb                : frame-buffer read port (master)
//   o_vga_r/g/b       : registered colour, o_vga_hs/vs registered syncs
//   o_frame_start     : one-cycle pulse on first output pixel of a frame
//   o_frame_cnt       : frames output since reset (wraps)
module vga_pixel_out
  import vga_pixel_out_pkg::*;
#(
  parameter int RAM_LAT = 2,
  parameter int ADDR_W  = $clog2(H_ACTIVE_PIX * V_ACTIVE_PIX),
  parameter int DATA_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_h_sync,
  input  logic                  i_v_sync,
  input  logic                  i_pixel,
  input  logic [ADDR_W-1:0]     i_p_count,
  input  logic [1:0]            i_mode,
  input  logic [DATA_W-1:0]     i_solid_rgb,
  vga_pixel_out_if.master       fb,
  output logic [3:0]            o_vga_r,
  output logic [3:0]            o_vga_g,
  output logic [3:0]            o_vga_b,
  output logic                  o_vga_hs,
  output logic                  o_vga_vs,
  output logic                  o_frame_start,
  output logic [15:0]           o_frame_cnt
);

  localparam int X_W       = $clog2(H_ACTIVE_PIX + 1);
  localparam int Y_W       = $clog2(V_ACTIVE_PIX);
  localparam int BAR_W     = $clog2(BAR_WIDTH);
  localparam int CHECK_BIT = 5;  // 32x32 squares

  mode_e             r_mode;
  logic              r_vs_q;
  logic              r_pix_q;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [BAR_W-1:0]  r_bar_sub;
  logic [2:0]        r_bar_idx;

  logic              w_vs_fall;
  logic              w_line_end;
  logic [DATA_W-1:0] w_pat_rgb;
  logic [DATA_W-1:0] w_pat_dly;
  ctl_t              w_ctl_in;
  ctl_t              w_ctl_dly;

  logic [DATA_W-1:0] r_rgb;
  logic              r_hs;
  logic              r_vs;
  logic              r_frame_start;
  logic [15:0]       r_frame_cnt;

  assign w_vs_fall  = r_vs_q & ~i_v_sync;
  assign w_line_end = r_pix_q & ~i_pixel;

  // Read request goes out in the input cycle; data returns RAM_LAT cycles later.
  assign fb.rd_en   = i_pixel && (r_mode == MODE_FB);
  assign fb.rd_addr = i_p_count;

  // Mode latch, edge history and pattern coordinate counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode    <= MODE_FB;
      r_vs_q    <= 1'b1;
      r_pix_q   <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_bar_sub <= '0;
      r_bar_idx <= '0;
    end else begin
      r_vs_q  <= i_v_sync;
      r_pix_q <= i_pixel;

      // Only at vsync start, so a frame never changes source part-way through.
      if (w_vs_fall) r_mode <= mode_e'(i_mode);

      if (i_pixel)      r_x <= r_x + X_W'(1);
      else if (r_pix_q) r_x <= '0;

      if (w_vs_fall)       r_y <= '0;
      else if (w_line_end) r_y <= r_y + Y_W'(1);

      // Bar position tracked with a sub-counter instead of dividing x by 80.
      // The index saturates at the last bar and only returns to 0 in blanking.
      if (!i_pixel) begin
        r_bar_sub <= '0;
        r_bar_idx <= '0;
      end else if (r_bar_sub == BAR_W'(BAR_WIDTH - 1)) begin
        r_bar_sub <= '0;
        if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_sub <= r_bar_sub + BAR_W'(1);
      end
    end
  end

  // NOTE: assign a default before the case so no path leaves w_pat_rgb unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_pat_rgb = '0;
    case (r_mode)
      MODE_BARS:  w_pat_rgb = bar_colour(r_bar_idx);
      MODE_CHECK: w_pat_rgb = (r_x[CHECK_BIT] ^ r_y[CHECK_BIT]) ? COL_WHITE : COL_BLACK;
      MODE_SOLID: w_pat_rgb = i_solid_rgb;
      default:    w_pat_rgb = '0;
    endcase
  end

  assign w_ctl_in = '{hs:   i_h_sync,
                      vs:   i_v_sync,
                      pix:  i_pixel,
                      fs:   i_pixel && (i_p_count == '0),
                      mode: r_mode};

  // Both delay lines match the frame-buffer read latency; the output register adds one more.
  vga_delay_line #(.WIDTH($bits(ctl_t)), .DEPTH(RAM_LAT), .RST_VAL(CTL_IDLE)) u_ctl_dly (
    .clk (clk),
    .rst (rst),
    .i_d (w_ctl_in),
    .o_q (w_ctl_dly)
  );

  vga_delay_line #(.WIDTH(DATA_W), .DEPTH(RAM_LAT)) u_pat_dly (
    .clk (clk),
    .rst (rst),
    .i_d (w_pat_rgb),
    .o_q (w_pat_dly)
  );

  // Output register; blanking forces black whatever the frame buffer returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb         <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_hs          <= w_ctl_dly.hs;
      r_vs          <= w_ctl_dly.vs;
      r_frame_start <= w_ctl_dly.fs;
      if (w_ctl_dly.fs) r_frame_cnt <= r_frame_cnt + 16'd1;

      if (!w_ctl_dly.pix)                r_rgb <= '0;
      else if (w_ctl_dly.mode == MODE_FB) r_rgb <= fb.rd_data;
      else                               r_rgb <= w_pat_dly;
    end
  end

  assign o_vga_r       = r_rgb[11:8];
  assign o_vga_g       = r_rgb[7:4];
  assign o_vga_b       = r_rgb[3:0];
  assign o_vga_hs      = r_hs;
  assign o_vga_vs      = r_vs;
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Directed bench for vga_pixel_out with RAM_LAT=2 (output latency 3 cycles).
// Frames are shortened vertically (few active lines, short vblank) but keep
// 640-pixel lines. Outputs are logged per cycle at the falling edge and
// compared afterwards against hand-computed values at input-cycle + 3.
module tb_vga_pixel_out;

  localparam int MAXC = 45000;
  localparam int LAT  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_h_sync = 1'b1;
  logic        i_v_sync = 1'b1;
  logic        i_pixel = 1'b0;
  logic [18:0] i_p_count = '0;
  logic [1:0]  i_mode = 2'b00;
  logic [11:0] i_solid_rgb = 12'hA5C;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;
  logic [15:0] frame_cnt;

  vga_pixel_out_if #(.ADDR_W(19), .DATA_W(12)) fb_if ();

  vga_pixel_out #(.RAM_LAT(2), .ADDR_W(19), .DATA_W(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_h_sync      (i_h_sync),
    .i_v_sync      (i_v_sync),
    .i_pixel       (i_pixel),
    .i_p_count     (i_p_count),
    .i_mode        (i_mode),
    .i_solid_rgb   (i_solid_rgb),
    .fb            (fb_if),
    .o_vga_r       (vga_r),
    .o_vga_g       (vga_g),
    .o_vga_b       (vga_b),
    .o_vga_hs      (vga_hs),
    .o_vga_vs      (vga_vs),
    .o_frame_start (frame_start),
    .o_frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: 2-cycle read latency, data = address[11:0]; 0xBAD when not read.
  logic [11:0] ram_p0, ram_p1;
  always @(posedge clk) begin
    ram_p0 <= fb_if.rd_en ? fb_if.rd_addr[11:0] : 12'hBAD;
    ram_p1 <= ram_p0;
  end
  assign fb_if.rd_data = ram_p1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rgb_log [MAXC];
  logic [15:0] hs_log  [MAXC];
  logic [15:0] vs_log  [MAXC];
  logic [15:0] fs_log  [MAXC];
  logic [15:0] cnt_log [MAXC];
  logic [15:0] en_log  [MAXC];

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      rgb_log[cyc] = 16'({vga_r, vga_g, vga_b});
      hs_log[cyc]  = 16'(vga_hs);
      vs_log[cyc]  = 16'(vga_vs);
      fs_log[cyc]  = 16'(frame_start);
      cnt_log[cyc] = frame_cnt;
      en_log[cyc]  = 16'(fb_if.rd_en);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int ls [64];
  int hs_fall, vs_fall, t_a, t_b, t_c, n_fs;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // vblank (20 front, 10 vsync, 30 back) then n_lines of 640 active + 20 blank (hsync 5..11).
  task automatic run_frame(input int n_lines, input int chg_line, input logic [1:0] chg_mode);
    for (int c = 0; c < 60; c++) begin
      i_pixel = 1'b0; i_p_count = '0; i_h_sync = 1'b1;
      i_v_sync = !(c >= 20 && c < 30);
      if (c == 20) vs_fall = cyc;
      step();
    end
    for (int l = 0; l < n_lines; l++) begin
      if (l == chg_line) i_mode = chg_mode;
      for (int x = 0; x < 640; x++) begin
        i_pixel = 1'b1; i_p_count = 19'(l * 640 + x); i_h_sync = 1'b1; i_v_sync = 1'b1;
        if (x == 0) ls[l] = cyc;
        step();
      end
      for (int c = 0; c < 20; c++) begin
        i_pixel = 1'b0; i_p_count = '0;
        i_h_sync = !(c >= 5 && c < 12);
        if (c == 5) hs_fall = cyc;
        step();
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", 16'({vga_r, vga_g, vga_b}), 16'h000);
    check("rst_hs", 16'(vga_hs), 16'h1);
    check("rst_vs", 16'(vga_vs), 16'h1);
    check("rst_fs", 16'(frame_start), 16'h0);
    check("rst_cnt", frame_cnt, 16'h0);
    rst = 1'b0;

    // Frame A: frame buffer
    i_mode = 2'b00;
    run_frame(2, -1, 2'b00);
    t_a = ls[0];
    check("A_blank_before", rgb_log[ls[0] + LAT - 1], 16'h000);
    check("A_px0", rgb_log[ls[0] + LAT], 16'h000);
    check("A_px4", rgb_log[ls[0] + 4 + LAT], 16'h004);
    check("A_px5", rgb_log[ls[0] + 5 + LAT], 16'h005);
    check("A_px639", rgb_log[ls[0] + 639 + LAT], 16'h27F);
    check("A_blank_after", rgb_log[ls[0] + 640 + LAT], 16'h000);
    check("A_l1_px5", rgb_log[ls[1] + 5 + LAT], 16'h285);
    check("A_rden_act", en_log[ls[0] + 10], 16'h1);
    check("A_rden_blank", en_log[ls[0] + 645], 16'h0);
    check("A_hs_pre", hs_log[hs_fall + LAT - 1], 16'h1);
    check("A_hs_fall", hs_log[hs_fall + LAT], 16'h0);
    check("A_hs_rise", hs_log[hs_fall + 7 + LAT], 16'h1);
    check("A_vs_pre", vs_log[vs_fall + LAT - 1], 16'h1);
    check("A_vs_fall", vs_log[vs_fall + LAT], 16'h0);
    check("A_vs_low_end", vs_log[vs_fall + 9 + LAT], 16'h0);
    check("A_vs_rise", vs_log[vs_fall + 10 + LAT], 16'h1);
    check("A_fs_pre", fs_log[ls[0] + LAT - 1], 16'h0);
    check("A_fs", fs_log[ls[0] + LAT], 16'h1);
    check("A_cnt", cnt_log[ls[0] + LAT], 16'h1);

    // Frame B: colour bars
    i_mode = 2'b01;
    run_frame(2, -1, 2'b00);
    t_b = ls[0];
    check("B_x0", rgb_log[ls[0] + LAT], 16'hFFF);
    check("B_x79", rgb_log[ls[0] + 79 + LAT], 16'hFFF);
    check("B_x80", rgb_log[ls[0] + 80 + LAT], 16'hFF0);
    check("B_x160", rgb_log[ls[0] + 160 + LAT], 16'h0FF);
    check("B_x320", rgb_log[ls[0] + 320 + LAT], 16'hF0F);
    check("B_x559", rgb_log[ls[0] + 559 + LAT], 16'h00F);
    check("B_x560", rgb_log[ls[0] + 560 + LAT], 16'h000);
    check("B_x639", rgb_log[ls[0] + 639 + LAT], 16'h000);
    check("B_blank", rgb_log[ls[0] + 641 + LAT], 16'h000);
    check("B_rden", en_log[ls[0] + 10], 16'h0);
    check("B_l1_x0", rgb_log[ls[1] + LAT], 16'hFFF);
    check("B_l1_x80", rgb_log[ls[1] + 80 + LAT], 16'hFF0);

    // Frame C: checkerboard
    i_mode = 2'b10;
    run_frame(34, -1, 2'b00);
    t_c = ls[0];
    check("C_x0_y0", rgb_log[ls[0] + LAT], 16'h000);
    check("C_x32_y0", rgb_log[ls[0] + 32 + LAT], 16'hFFF);
    check("C_x31_y0", rgb_log[ls[0] + 31 + LAT], 16'h000);
    check("C_x0_y32", rgb_log[ls[32] + LAT], 16'hFFF);
    check("C_x32_y32", rgb_log[ls[32] + 32 + LAT], 16'h000);
    check("C_x64_y33", rgb_log[ls[33] + 64 + LAT], 16'hFFF);
    n_fs = 0;
    for (int c = 0; c < cyc && c < MAXC; c++) if (fs_log[c] == 16'h1) n_fs++;
    check("ABC_fs_pulses", 16'(n_fs), 16'd3);
    check("B_fs", fs_log[t_b + LAT], 16'h1);
    check("C_fs", fs_log[t_c + LAT], 16'h1);
    check("C_cnt_pre", cnt_log[t_c + LAT - 1], 16'd2);
    check("C_cnt", cnt_log[t_c + LAT], 16'd3);
    check("A_fs_again", fs_log[t_a + LAT], 16'h1);

    // Frame D: frame buffer, request solid mid-frame
    i_mode = 2'b00;
    run_frame(2, 1, 2'b11);
    check("D_px5", rgb_log[ls[0] + 5 + LAT], 16'h005);
    check("D_l1_px5", rgb_log[ls[1] + 5 + LAT], 16'h285);
    check("D_l1_rden", en_log[ls[1] + 10], 16'h1);

    // Frame E: solid
    run_frame(2, -1, 2'b00);
    check("E_px0", rgb_log[ls[0] + LAT], 16'hA5C);
    check("E_l1_px5", rgb_log[ls[1] + 5 + LAT], 16'hA5C);
    check("E_blank", rgb_log[ls[0] + 640 + LAT], 16'h000);
    check("E_rden", en_log[ls[0] + 5], 16'h0);

    // Frame F: counter wrap, then async reset mid-line
    force dut.r_frame_cnt = 16'hFFFF;
    step();
    release dut.r_frame_cnt;
    fork
      run_frame(2, -1, 2'b00);
      begin
        repeat (360) @(posedge clk);
        #3;
        check("F_pre_rst_rgb", 16'({vga_r, vga_g, vga_b}), 16'hA5C);
        rst = 1'b1;
        #1;
        check("F_rst_rgb", 16'({vga_r, vga_g, vga_b}), 16'h000);
        check("F_rst_hs", 16'(vga_hs), 16'h1);
        check("F_rst_vs", 16'(vga_vs), 16'h1);
        check("F_rst_cnt", frame_cnt, 16'h0);
        repeat (2) @(posedge clk);
        #4;
        rst = 1'b0;
      end
    join
    check("F_cnt_pre", cnt_log[ls[0] + LAT - 1], 16'hFFFF);
    check("F_cnt_wrap", cnt_log[ls[0] + LAT], 16'h0);
    check("F_fs", fs_log[ls[0] + LAT], 16'h1);
    check("F_l1_px5_fb", rgb_log[ls[1] + 5 + LAT], 16'h285);

    // Frame G: next frame after reset
    run_frame(2, -1, 2'b00);
    check("G_px0", rgb_log[ls[0] + LAT], 16'hA5C);
    check("G_l1_px100", rgb_log[ls[1] + 100 + LAT], 16'hA5C);
    check("G_fs", fs_log[ls[0] + LAT], 16'h1);
    check("G_cnt", cnt_log[ls[0] + LAT], 16'd1);

    repeat (10) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
